// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-lite codes, FSM state type and byte-strobe helper for ahb_sram_slave.
package ahb_sram_slave_pkg;

    localparam int AHB_ADDR_WIDTH = 32;
    localparam int AHB_DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_strobe = 4'b0001 << addr;
            HSIZE_HALF: byte_strobe = addr[1] ? 4'b1100 : 4'b0011;
            default:    byte_strobe = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Single-port-per-direction 32-bit SRAM with byte write enables and a registered read port.
// The array is exposed as mem[] so simulation images can be preloaded hierarchically.
module ahb_sram_mem #(
    parameter int MEM_DEPTH = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
    input  logic [3:0]                   wr_be,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [MEM_DEPTH];

    // NOTE: the storage array has no reset; only the read-data register does.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: transfer decode, two-cycle ERROR, write-to-read forwarding.
// Define AHB_SRAM_WAIT_EN to build the WAIT state and its WAIT_CYCLES down-counter.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]                HTRANS,
    input  logic [2:0]                HSIZE,
    input  logic                      HWRITE,
    input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic [AHB_DATA_WIDTH-1:0] HRDATA,
    output logic                      HRESP
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t       state;
    logic [1:0]   addr_q;
    logic [2:0]   size_q;
    logic         write_q;
    logic [AW-1:0] idx_q;
    logic [3:0]   fwd_strb;
    logic [31:0]  fwd_data;
    logic [31:0]  mem_rdata;
`ifdef AHB_SRAM_WAIT_EN
    logic [3:0]   wait_cnt;
`endif

    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          legal;
    logic          rd_en;
    logic          wr_commit;
    logic          raw_hit;
    logic [3:0]    wr_strb;
    logic [AW-1:0] idx;

    // HREADYOUT high means the current data phase (if any) ends at this edge.
    assign accept = HSEL && HREADY && HREADYOUT &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    assign idx          = HADDR[AW+1:2];
    assign out_of_range = {2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH);
    assign misaligned   = (HSIZE == HSIZE_HALF && HADDR[0]) ||
                          (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign legal        = (HSIZE <= HSIZE_WORD) && !misaligned && !out_of_range;

    assign rd_en     = accept && legal && !HWRITE;
    assign wr_commit = (state == ST_DATA) && write_q;
    assign wr_strb   = wr_commit ? byte_strobe(size_q, addr_q) : 4'b0000;
    assign raw_hit   = rd_en && wr_commit && (idx == idx_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            addr_q    <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            fwd_strb  <= '0;
            fwd_data  <= '0;
`ifdef AHB_SRAM_WAIT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            // The array read misses a write committing on the same edge; keep its lanes aside.
            if (rd_en) begin
                fwd_strb <= raw_hit ? wr_strb : 4'b0000;
                fwd_data <= HWDATA;
            end

            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[1:0];
                        size_q  <= HSIZE;
                        write_q <= HWRITE;
                        idx_q   <= idx;
                        if (!legal) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
`ifdef AHB_SRAM_WAIT_EN
                        end else if (WAIT_CYCLES != 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= 4'(WAIT_CYCLES - 1);
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
`endif
                        end else begin
                            state     <= ST_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
`ifdef AHB_SRAM_WAIT_EN
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`endif
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // NOTE: assign a default before the loop so no lane can infer a latch.
    always_comb begin
        HRDATA = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_strb[i]) begin
                HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
            end
        end
    end

    ahb_sram_mem #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .rd_en   (rd_en),
        .rd_addr (idx),
        .wr_be   (wr_strb),
        .wr_addr (idx_q),
        .wdata   (HWDATA),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed table, reset-abort sequence, random traffic
// against a word-array reference model. Works with or without AHB_SRAM_WAIT_EN.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam int DEPTH = 256;
`ifdef AHB_SRAM_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(
        .MEM_DEPTH   (DEPTH),
        .WAIT_CYCLES (3)
    ) dut (
        .HCLK      (hclk),
        .HRESETn   (hresetn),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HWRITE    (hwrite),
        .HWDATA    (hwdata),
        .HREADY    (hready),
        .HREADYOUT (hreadyout),
        .HRDATA    (hrdata),
        .HRESP     (hresp)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    op_t         pend;
    bit          pend_v = 1'b0;
    bit          p_active;
    bit          p_err;
    bit          p_chk_rd;
    int          p_waits;
    logic [31:0] p_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        op_t o;
        o.sel   = sel;
        o.trans = trans;
        o.write = write;
        o.size  = size;
        o.addr  = addr;
        o.wdata = wdata;
        return o;
    endfunction

    function automatic bit m_legal(input op_t o);
        if (o.size > 3'd2) return 1'b0;
        if ((o.addr % (32'd1 << o.size)) != 0) return 1'b0;
        if ((o.addr / 4) >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_write(input op_t o);
        int w;
        int lane;
        w = int'(o.addr / 4);
        for (int b = 0; b < (1 << o.size); b++) begin
            lane = int'(o.addr % 4) + b;
            model[w][8*lane +: 8] = o.wdata[8*lane +: 8];
        end
    endtask

    // Called at a falling edge: presents nxt's address phase and completes the pending data phase.
    task automatic step(input op_t nxt, input bit use_tab, input bit t_err, input logic [31:0] t_rdata);
        int waits;
        bit resp_ok;
        waits   = 0;
        resp_ok = 1'b1;
        hsel   = nxt.sel;
        htrans = nxt.trans;
        haddr  = nxt.addr;
        hsize  = nxt.size;
        hwrite = nxt.write;
        hwdata = (pend_v && pend.write) ? pend.wdata : 32'h0;
        #1;
        while (hreadyout !== 1'b1 && waits < 40) begin
            if (hresp !== p_err) resp_ok = 1'b0;
            waits++;
            @(posedge hclk);
            @(negedge hclk);
            #1;
        end
        if (pend_v) begin
            check("wait_cycles", waits, p_waits);
            check("hresp_final", {31'b0, hresp}, {31'b0, p_err});
            check("hresp_stall", {31'b0, resp_ok}, 32'd1);
            if (p_chk_rd) check("hrdata", hrdata, p_rdata);
            if (p_active && !p_err && pend.write) m_write(pend);
        end
        @(posedge hclk);
        @(negedge hclk);
        pend     = nxt;
        pend_v   = 1'b1;
        p_active = nxt.sel && nxt.trans[1];
        p_err    = use_tab ? t_err : (p_active && !m_legal(nxt));
        p_waits  = p_err ? 1 : (p_active ? W : 0);
        p_chk_rd = p_active && !p_err && !nxt.write;
        p_rdata  = 32'h0;
        if (p_chk_rd) p_rdata = use_tab ? t_rdata : model[nxt.addr / 4];
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tab[$];
        op_t  idle_op;
        op_t  o;
        int   r;

        idle_op = mk(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        hresetn = 1'b0;
        hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hsize = '0; hwrite = 1'b0; hwdata = '0;
        repeat (2) @(negedge hclk);
        check("reset_hreadyout", {31'b0, hreadyout}, 32'd1);
        check("reset_hresp", {31'b0, hresp}, 32'd0);
        check("reset_hrdata", hrdata, 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        // Bring every word to a known zero through the bus.
        for (int i = 0; i < DEPTH; i++) step(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(i * 4), 32'h0), 0, 0, 0);

        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'hDEADBEEF});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h11223344), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h22, 32'h00AA0000), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h20, 32'h00005566), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0), 1'b0, 32'h11AA5566});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, 32'hCAFEF00D), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0), 1'b0, 32'hCAFEF00D});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h02, 32'h0), 1'b1, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, 3'd3, 32'h10, 32'h0), 1'b1, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'(DEPTH * 4), 32'hFFFFFFFF), 1'b1, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h12, 32'h12345678), 1'b1, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h11, 32'h0000BBBB), 1'b1, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'hDEADBEEF});
        tab.push_back('{mk(1, HTRANS_IDLE, 1, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_BUSY, 1, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'h0});
        tab.push_back('{mk(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h10, 32'h0), 1'b0, 32'hDEADBEEF});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h31, 32'h00007700), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0), 1'b0, 32'hCAFE770D});
        tab.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h3A, 32'h99880000), 1'b0, 32'h0});
        tab.push_back('{mk(1, HTRANS_SEQ, 0, HSIZE_HALF, 32'h3A, 32'h0), 1'b0, 32'h99880000});

        foreach (tab[i]) step(tab[i].op, 1'b1, tab[i].exp_err, tab[i].exp_rdata);
        step(idle_op, 0, 0, 0);

        // Reset during a write data phase: the write must be dropped.
        step(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0), 1, 0, 32'hDEADBEEF);
        step(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h12345678), 1, 0, 32'h0);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h12345678;
        #1;
        check("pre_rst_hreadyout", {31'b0, hreadyout}, (W == 0) ? 32'd1 : 32'd0);
        check("pre_rst_hrdata", hrdata, 32'hDEADBEEF);
        #1;
        hresetn = 1'b0;
        #1;
        check("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
        check("rst_hresp", {31'b0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        pend_v = 1'b0;
        @(negedge hclk);
        step(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 32'h0), 1, 0, 32'h0);
        step(idle_op, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            o.sel   = ($urandom_range(0, 19) != 0);
            o.trans = (r < 5) ? HTRANS_IDLE : (r < 10) ? HTRANS_BUSY : (r < 40) ? HTRANS_SEQ : HTRANS_NONSEQ;
            o.size  = ($urandom_range(0, 29) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            o.addr  = 32'($urandom_range(0, 31) * 4);
            if (o.size == 3'd0) o.addr = o.addr + 32'($urandom_range(0, 3));
            if (o.size == 3'd1) o.addr = o.addr + 32'(2 * $urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) o.addr = o.addr + 32'd1;
            if ($urandom_range(0, 29) == 0) o.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
            o.write = 1'($urandom_range(0, 1));
            o.wdata = $urandom;
            step(o, 0, 0, 0);
        end
        step(idle_op, 0, 0, 0);

        for (int i = 0; i < 32; i++) step(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'(i * 4), 32'h0), 0, 0, 0);
        step(idle_op, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
